ibex_csr_rmw_ctrl: RTL and testbench

IBEX_CSR_RMW_CTRL -- requirements
Module: ibex_csr_rmw_ctrl

---
 rtl/ibex_pkg.sv | 12 +
 rtl/ibex_csr_rmw_ctrl.sv | 119 +++++++++++
 tb/tb_ibex_csr_rmw_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the CSR access controller.
// Only the CSR operation encoding is needed here.
package ibex_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

endpackage

// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write sequencer for a shadowed CSR primitive: reads the CSR, applies
// the requested operation, writes it back, optionally re-reads it to verify, then responds.
module ibex_csr_rmw_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned Width      = 32,
  parameter bit          WriteCheck = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  csr_op_e          req_op_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Width-1:0] csr_rdata_i,
  input  logic             csr_rd_error_i,
  output logic             csr_wr_en_o,
  output logic [Width-1:0] csr_wr_data_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_error_o,
  output logic [7:0]       err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    RMW,
    WRITE,
    VERIFY,
    RESP
  } state_e;

  localparam logic [7:0] ErrCntMax = 8'hFF;

  state_e           state_q, state_d;
  csr_op_e          op_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] old_q;
  logic [Width-1:0] new_q;
  logic             err_q;
  logic [7:0]       err_cnt_q;

  logic [Width-1:0] new_val;
  logic             no_write;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    new_val = csr_rdata_i;
    unique case (op_q)
      CSR_OP_WRITE: new_val = wdata_q;
      CSR_OP_SET:   new_val = csr_rdata_i | wdata_q;
      CSR_OP_CLEAR: new_val = csr_rdata_i & ~wdata_q;
      default:      new_val = csr_rdata_i;
    endcase
  end

  // SET/CLEAR with an empty mask cannot change the CSR, so skip the write.
  assign no_write = (op_q == CSR_OP_READ) ||
                    (((op_q == CSR_OP_SET) || (op_q == CSR_OP_CLEAR)) && (wdata_q == '0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = RMW;
      RMW:     state_d = (csr_rd_error_i || no_write) ? RESP : WRITE;
      WRITE:   state_d = WriteCheck ? VERIFY : RESP;
      VERIFY:  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= CSR_OP_READ;
      wdata_q   <= '0;
      old_q     <= '0;
      new_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q    <= req_op_i;
            wdata_q <= req_wdata_i;
          end
        end
        RMW: begin
          old_q <= csr_rdata_i;
          new_q <= new_val;
          err_q <= csr_rd_error_i;
        end
        VERIFY: begin
          if ((csr_rdata_i != new_q) || csr_rd_error_i) err_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready_i && err_q && (err_cnt_q != ErrCntMax)) err_cnt_q <= err_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign csr_wr_en_o   = (state_q == WRITE);
  assign csr_wr_data_o = (state_q == WRITE) ? new_q : '0;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = (state_q == RESP) ? old_q : '0;
  assign rsp_error_o   = (state_q == RESP) && err_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Self-checking bench: a bench-side CSR store plus a transaction-level model of
// the controller, compared against the DUT on every falling clock edge.
module tb_ibex_csr_rmw_ctrl;
  import ibex_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  csr_op_e       req_op = CSR_OP_READ;
  logic [W-1:0]  req_wdata = '0;
  logic [W-1:0]  csr_rdata;
  logic          csr_rd_error;
  logic          csr_wr_en;
  logic [W-1:0]  csr_wr_data;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_error;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  ibex_csr_rmw_ctrl #(.Width(W), .WriteCheck(1'b1)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_wdata_i   (req_wdata),
    .csr_rdata_i   (csr_rdata),
    .csr_rd_error_i(csr_rd_error),
    .csr_wr_en_o   (csr_wr_en),
    .csr_wr_data_o (csr_wr_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_error_o   (rsp_error),
    .err_cnt_o     (err_cnt)
  );

  // Bench-side CSR primitive with fault injection hooks.
  logic [W-1:0] csr_mem;
  logic         post_wr;
  bit           inj_rd_err = 1'b0;
  bit           corrupt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_mem <= '0;
      post_wr <= 1'b0;
    end else begin
      post_wr <= csr_wr_en;
      if (csr_wr_en) csr_mem <= csr_wr_data;
    end
  end

  assign csr_rdata    = (corrupt && post_wr) ? 32'h0000_DEAD : csr_mem;
  assign csr_rd_error = inj_rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Transaction-level reference model.
  function automatic logic [31:0] apply_op(csr_op_e op, logic [31:0] cur, logic [31:0] wd);
    case (op)
      CSR_OP_WRITE: return wd;
      CSR_OP_SET:   return cur | wd;
      CSR_OP_CLEAR: return cur & ~wd;
      default:      return cur;
    endcase
  endfunction

  function automatic bit will_write(csr_op_e op, logic [31:0] wd, bit inj);
    if (inj || op == CSR_OP_READ) return 1'b0;
    if ((op == CSR_OP_SET || op == CSR_OP_CLEAR) && wd == 0) return 1'b0;
    return 1'b1;
  endfunction

  bit           m_active = 1'b0;
  int           m_k = 0;
  int           m_lat = 0;
  logic [31:0]  m_csr = '0;
  logic [31:0]  m_old = '0;
  logic [31:0]  m_new = '0;
  bit           m_write = 1'b0;
  bit           m_err = 1'b0;
  int           m_cnt = 0;
  int           n_acc = 0;
  int           n_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_csr    <= '0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_old    <= m_csr;
        m_new    <= apply_op(req_op, m_csr, req_wdata);
        m_write  <= will_write(req_op, req_wdata, inj_rd_err);
        m_err    <= inj_rd_err || (will_write(req_op, req_wdata, inj_rd_err) && corrupt);
        m_lat    <= will_write(req_op, req_wdata, inj_rd_err) ? 4 : 2;
        n_acc    <= n_acc + 1;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k >= m_lat && rsp_ready) begin
        m_active <= 1'b0;
        if (m_write) m_csr <= m_new;
        if (m_err && m_cnt < 255) m_cnt <= m_cnt + 1;
        n_done <= n_done + 1;
      end
    end
  end

  logic exp_valid, exp_wr;
  assign exp_valid = m_active && (m_k >= m_lat);
  assign exp_wr    = m_active && m_write && (m_k == 2);

  // Observations recorded for the literal checks.
  int          wr_seen = 0;
  int          rsp_seen = 0;
  int          last_lat = 0;
  logic [31:0] last_wr = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", 32'(req_ready), 32'(!m_active));
      check("wr_en", 32'(csr_wr_en), 32'(exp_wr));
      check("wr_data", csr_wr_data, exp_wr ? m_new : 32'h0);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("rsp_rdata", rsp_rdata, m_old);
        check("rsp_error", 32'(rsp_error), 32'(m_err));
      end
      check("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (csr_wr_en) begin
        wr_seen <= wr_seen + 1;
        last_wr <= csr_wr_data;
      end
      if (rsp_valid && !prev_valid) begin
        rsp_seen   <= rsp_seen + 1;
        last_lat   <= m_k;
        last_rdata <= rsp_rdata;
        last_err   <= rsp_error;
      end
      prev_valid <= rsp_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic run_txn(input csr_op_e op, input logic [31:0] wd, input bit inj,
                         input bit cor, input int hold, input bit keep);
    int acc0, done0, cnt;
    bit ok;
    acc0  = n_acc;
    done0 = n_done;
    @(negedge clk);
    req_op     = op;
    req_wdata  = wd;
    inj_rd_err = inj;
    corrupt    = cor;
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_acc != acc0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout_fail("accept");
      req_valid = 1'b0;
      return;
    end
    if (!keep) req_valid = 1'b0;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rsp_ready = (cnt >= hold);
      cnt++;
      @(negedge clk);
      if (n_done != done0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("response");
    rsp_ready = 1'b0;
    if (!keep) begin
      inj_rd_err = 1'b0;
      corrupt    = 1'b0;
    end
  endtask

  initial begin
    int w0, r0;
    bit ok;
    csr_op_e op;
    logic [31:0] wd;

    // Reset values.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_wr_en", 32'(csr_wr_en), 32'h0);
    check("rst_wr_data", csr_wr_data, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SET 0x0F onto 0xF0.
    run_txn(CSR_OP_WRITE, 32'h0000_00F0, 1'b0, 1'b0, 0, 1'b0);
    w0 = wr_seen;
    run_txn(CSR_OP_SET, 32'h0000_000F, 1'b0, 1'b0, 0, 1'b0);
    check("set_wr_count", 32'(wr_seen - w0), 32'd1);
    check("set_wr_data", last_wr, 32'h0000_00FF);
    check("set_latency", 32'(last_lat), 32'd4);
    check("set_rdata", last_rdata, 32'h0000_00F0);
    check("set_error", 32'(last_err), 32'h0);

    // CLEAR with an empty mask issues no write.
    w0 = wr_seen;
    run_txn(CSR_OP_CLEAR, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    check("clr0_wr_count", 32'(wr_seen - w0), 32'd0);
    check("clr0_rdata", last_rdata, 32'h0000_00FF);
    check("clr0_latency", 32'(last_lat), 32'd2);

    // Shadow mismatch during the read phase.
    check("err_cnt_before", 32'(err_cnt), 32'h0);
    w0 = wr_seen;
    run_txn(CSR_OP_WRITE, 32'h0000_1234, 1'b1, 1'b0, 0, 1'b0);
    check("rderr_wr_count", 32'(wr_seen - w0), 32'd0);
    check("rderr_error", 32'(last_err), 32'h1);
    check("rderr_err_cnt", 32'(err_cnt), 32'h1);

    // Back-pressure: response held while consumer stalls.
    run_txn(CSR_OP_READ, 32'h0, 1'b0, 1'b0, 9, 1'b0);
    check("stall_rdata", last_rdata, 32'h0000_00FF);

    // Request held through RESP is only accepted after the handshake.
    r0 = rsp_seen;
    run_txn(CSR_OP_READ, 32'h0, 1'b0, 1'b0, 2, 1'b1);
    run_txn(CSR_OP_READ, 32'h0, 1'b0, 1'b0, 1, 1'b0);
    check("b2b_responses", 32'(rsp_seen - r0), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      op = csr_op_e'(2'($urandom_range(0, 3)));
      case ($urandom_range(0, 3))
        0:       wd = 32'h0;
        1:       wd = 32'h1 << $urandom_range(0, 31);
        default: wd = $urandom;
      endcase
      run_txn(op, wd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
              $urandom_range(0, 3), 1'b0);
    end

    // Verify-phase corruption, saturating the error counter.
    for (int n = 0; n < 256; n++) begin
      run_txn(CSR_OP_WRITE, 32'h0000_BEEF, 1'b0, 1'b1, 0, 1'b0);
      if (n == 0) check("verify_error", 32'(last_err), 32'h1);
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'hFF);

    // Reset while the write strobe is up abandons the access.
    @(negedge clk);
    req_op    = CSR_OP_WRITE;
    req_wdata = 32'h0000_5555;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      req_valid = m_active ? 1'b0 : 1'b1;
      if (exp_wr) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("reach_write");
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(csr_wr_en), 32'h0);
    check("mid_rst_wr_data", csr_wr_data, 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'h1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_rsp_error", 32'(rsp_error), 32'h0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_seen;
    r0 = rsp_seen;
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_no_write", 32'(wr_seen - w0), 32'd0);
    check("post_rst_no_rsp", 32'(rsp_seen - r0), 32'd0);
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
